// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - funct codes, FSM states and defaults shared by the multiply/divide unit
package muldiv_pkg;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - ID-stage decode inputs and HI/LO/stall outputs of the multiply/divide unit
interface muldiv_ctrl_if import muldiv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);
  logic            id_valid;
  logic            flush;
  logic [5:0]      id_op;
  logic [5:0]      id_funct;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            stall;
  logic            busy;
  logic            unsup;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mf_data;

  modport master (
    output id_valid, flush, id_op, id_funct, rs_val, rt_val,
    input  stall, busy, unsup, hi, lo, mf_data
  );
  modport slave (
    input  id_valid, flush, id_op, id_funct, rs_val, rt_val,
    output stall, busy, unsup, hi, lo, mf_data
  );
endinterface

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - unsigned radix-2 shift-add multiply / restoring divide datapath
module mdu_iter_core import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            mode_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);
  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] d;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // acc is the running high product / partial remainder; q holds multiplier bits or quotient bits
  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
    shifted = {acc, q[XLEN-1]};
    diff    = shifted - {1'b0, d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      q   <= '0;
      d   <= '0;
    end else if (start) begin
      cnt <= CW'(XLEN - 1);
      acc <= '0;
      q   <= a;
      d   <= b;
    end else if (step) begin
      cnt <= cnt - CW'(1);
      if (mode_div) begin
        if (!diff[XLEN]) begin
          acc <= diff[XLEN-1:0];
          q   <= {q[XLEN-2:0], 1'b1};
        end else begin
          acc <= shifted[XLEN-1:0];
          q   <= {q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc <= sum[XLEN:1];
        q   <= {sum[0], q[XLEN-1:1]};
      end
    end
  end

  assign done   = (cnt == '0);
  assign res_hi = acc;
  assign res_lo = q;
endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MIPS mult/div decode, stall generation, sign handling, FSM and HI/LO registers
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter bit DIV_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);
  state_t            state;
  logic              busy_q, unsup_q, op_div, neg_q, neg_r, div0;
  logic [XLEN-1:0]   hi_q, lo_q, dividend;
  logic              live, is_mul, is_div, is_signed, is_hilo, issue, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b, core_hi, core_lo, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod_fix;
  logic              core_done;

  always_comb begin
    live      = bus.id_valid & ~bus.flush & (bus.id_op == 6'd0);
    is_mul    = bus.id_funct inside {FN_MULT, FN_MULTU};
    is_div    = (bus.id_funct inside {FN_DIV, FN_DIVU}) & DIV_EN;
    is_signed = bus.id_funct inside {FN_MULT, FN_DIV};
    is_hilo   = bus.id_funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO};
    issue     = live & (state == IDLE) & (is_mul | is_div);
    sa        = is_signed & bus.rs_val[XLEN-1];
    sb        = is_signed & bus.rt_val[XLEN-1];
    mag_a     = sa ? -bus.rs_val : bus.rs_val;
    mag_b     = sb ? -bus.rt_val : bus.rt_val;
    prod_fix  = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    quo_fix   = neg_q ? -core_lo : core_lo;
    rem_fix   = neg_r ? -core_hi : core_hi;
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (issue),
    .step     (state == MUL || state == DIV),
    .mode_div (state == DIV),
    .a        (mag_a),
    .b        (mag_b),
    .done     (core_done),
    .res_hi   (core_hi),
    .res_lo   (core_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      unsup_q  <= 1'b0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      dividend <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unsup_q <= live & !DIV_EN & (bus.id_funct inside {FN_DIV, FN_DIVU});
      case (state)
        IDLE: begin
          if (issue) begin
            state    <= is_div ? DIV : MUL;
            busy_q   <= 1'b1;
            op_div   <= is_div;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            div0     <= (bus.rt_val == '0);
            dividend <= bus.rs_val;
          end else if (live && bus.id_funct == FN_MTHI) begin
            hi_q <= bus.rs_val;
          end else if (live && bus.id_funct == FN_MTLO) begin
            lo_q <= bus.rs_val;
          end
        end
        MUL, DIV: if (core_done) state <= FIX;
        FIX: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!op_div) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (div0) begin
            // divide by zero bypasses the datapath result entirely
            hi_q <= dividend;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.unsup   = unsup_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.stall   = live & busy_q & (is_mul | is_div | is_hilo);
  assign bus.mf_data = (live && bus.id_funct == FN_MFHI) ? hi_q :
                       (live && bus.id_funct == FN_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized self-checking bench for muldiv_ctrl against an arithmetic model
module tb_muldiv_ctrl;
  import muldiv_pkg::*;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.XLEN(XLEN)) bus ();
  muldiv_ctrl_if #(.XLEN(XLEN)) bus_nd ();

  muldiv_ctrl #(.XLEN(XLEN), .DIV_EN(1'b1)) dut    (.clk(clk), .rst(rst), .bus(bus));
  muldiv_ctrl #(.XLEN(XLEN), .DIV_EN(1'b0)) dut_nd (.clk(clk), .rst(rst), .bus(bus_nd));

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // Architectural HI/LO model from plain integer arithmetic
  function automatic void model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (fn)
      FN_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      FN_MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      FN_DIV: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
        else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      FN_DIVU: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      FN_MTHI: m_hi = a;
      FN_MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.id_valid = v; bus.flush = f; bus.id_op = op; bus.id_funct = fn; bus.rs_val = a; bus.rt_val = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 6'd0, 6'd0, '0, '0);
  endtask

  task automatic issue_wait(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, output int n);
    drive(1'b1, 1'b0, 6'd0, fn, a, b);
    tick();
    idle();
    n = 0;
    while (bus.busy && n < 100) begin n++; tick(); end
  endtask

  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    checks++; if (bus_nd.unsup !== 1'b0) begin errors++; $display("FAIL reset_unsup got %b want 0", bus_nd.unsup); end
  endtask

  task automatic test_directed();
    logic [5:0]  fns [6] = '{FN_MULT, FN_DIVU, FN_DIV, FN_DIV, FN_DIV, FN_DIVU};
    logic [31:0] as  [6] = '{32'd7, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] bs  [6] = '{32'hFFFF_FFF9, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    int n;
    for (int i = 0; i < 6; i++) begin
      issue_wait(fns[i], as[i], bs[i], n);
      model(fns[i], as[i], bs[i]);
      checks++; if (n !== XLEN + 1) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, n, XLEN + 1); end
      checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL dir%0d_hi got %h want %h", i, bus.hi, m_hi); end
      checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL dir%0d_lo got %h want %h", i, bus.lo, m_lo); end
    end
  endtask

  task automatic test_random();
    logic [5:0]  fn;
    logic [31:0] a, b;
    int n, sel;
    for (int i = 0; i < 24; i++) begin
      fn  = FN_MULT + 6'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      else if (sel == 3) begin b = $urandom_range(1, 9); b = -b; end
      issue_wait(fn, a, b, n);
      model(fn, a, b);
      checks++; if (n !== XLEN + 1) begin errors++; $display("FAIL rnd%0d_busy_cycles got %0d want %0d", i, n, XLEN + 1); end
      checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL rnd%0d_hi fn=%h a=%h b=%h got %h want %h", i, fn, a, b, bus.hi, m_hi); end
      checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL rnd%0d_lo fn=%h a=%h b=%h got %h want %h", i, fn, a, b, bus.lo, m_lo); end
    end
  endtask

  task automatic test_stall_mfhi();
    logic [31:0] a, b;
    int n;
    drive(1'b1, 1'b0, 6'd0, FN_MULTU, '1, '1);
    tick();
    drive(1'b1, 1'b0, 6'd0, FN_MFHI, '0, '0);
    n = 0;
    for (int i = 0; i < 100; i++) begin #1; if (!bus.stall) break; n++; tick(); end
    model(FN_MULTU, '1, '1);
    checks++; if (n !== XLEN + 1) begin errors++; $display("FAIL mfhi_stall_cycles got %0d want %0d", n, XLEN + 1); end
    checks++; if (bus.mf_data !== m_hi) begin errors++; $display("FAIL mfhi_data got %h want %h", bus.mf_data, m_hi); end
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL mfhi_lo got %h want %h", bus.lo, m_lo); end
    tick();
    // non-mul/div traffic while busy must not stall; HI/LO traffic must
    a = $urandom; b = $urandom;
    drive(1'b1, 1'b0, 6'd0, FN_MULT, a, b);
    tick();
    drive(1'b1, 1'b0, 6'd0, 6'h20, a, b); #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL add_stall got %b want 0", bus.stall); end
    drive(1'b1, 1'b0, 6'h23, FN_MULT, a, b); #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lw_stall got %b want 0", bus.stall); end
    drive(1'b1, 1'b0, 6'd0, FN_MTLO, a, b); #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mtlo_busy_stall got %b want 1", bus.stall); end
    idle();
    n = 0;
    while (bus.busy && n < 100) begin n++; tick(); end
    model(FN_MULT, a, b);
    checks++; if (n !== XLEN + 1) begin errors++; $display("FAIL midop_busy_cycles got %0d want %0d", n, XLEN + 1); end
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL midop_hi got %h want %h", bus.hi, m_hi); end
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL midop_lo got %h want %h", bus.lo, m_lo); end
  endtask

  task automatic test_mthi();
    logic [31:0] v;
    drive(1'b1, 1'b0, 6'd0, FN_MTHI, 32'h1234, '0);
    tick();
    model(FN_MTHI, 32'h1234, '0);
    drive(1'b1, 1'b0, 6'd0, FN_MFLO, '0, '0); #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mflo_stall got %b want 0", bus.stall); end
    checks++; if (bus.mf_data !== m_lo) begin errors++; $display("FAIL mflo_data got %h want %h", bus.mf_data, m_lo); end
    drive(1'b1, 1'b0, 6'd0, FN_MFHI, '0, '0); #1;
    checks++; if (bus.mf_data !== 32'h1234) begin errors++; $display("FAIL mthi_mfhi_data got %h want 00001234", bus.mf_data); end
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL mthi_hi got %h want %h", bus.hi, m_hi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
    v = $urandom;
    drive(1'b1, 1'b0, 6'd0, FN_MTLO, v, '0);
    tick();
    model(FN_MTLO, v, '0);
    idle(); #1;
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL mtlo_lo got %h want %h", bus.lo, m_lo); end
    checks++; if (bus.mf_data !== '0) begin errors++; $display("FAIL idle_mf_data got %h want 0", bus.mf_data); end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 6'd0, FN_MULT, 32'd3, 32'd5);
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_mult_busy got %b want 0", bus.busy); end
    drive(1'b0, 1'b0, 6'd0, FN_DIV, 32'd3, 32'd5);
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL invalid_div_busy got %b want 0", bus.busy); end
    drive(1'b1, 1'b1, 6'd0, FN_MTHI, 32'hCAFE_0000, '0);
    tick();
    idle();
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL flush_mthi_hi got %h want %h", bus.hi, m_hi); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c, d;
    int n;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom_range(1, 1000);
    drive(1'b1, 1'b0, 6'd0, FN_MULT, a, b);
    tick();
    drive(1'b1, 1'b0, 6'd0, FN_DIV, c, d);
    n = 0;
    for (int i = 0; i < 100; i++) begin #1; if (!bus.stall) break; n++; tick(); end
    model(FN_MULT, a, b);
    checks++; if (n !== XLEN + 1) begin errors++; $display("FAIL b2b_stall_cycles got %0d want %0d", n, XLEN + 1); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got %b want 0", bus.busy); end
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL b2b_mult_hi got %h want %h", bus.hi, m_hi); end
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL b2b_mult_lo got %h want %h", bus.lo, m_lo); end
    tick();
    idle();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_issue got %b want 1", bus.busy); end
    n = 0;
    while (bus.busy && n < 100) begin n++; tick(); end
    model(FN_DIV, c, d);
    checks++; if (n !== XLEN + 1) begin errors++; $display("FAIL b2b_div_cycles got %0d want %0d", n, XLEN + 1); end
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL b2b_div_hi got %h want %h", bus.hi, m_hi); end
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL b2b_div_lo got %h want %h", bus.lo, m_lo); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 6'd0, FN_MTHI, 32'h5A5A_0001, '0);
    tick();
    drive(1'b1, 1'b0, 6'd0, FN_MULT, 32'h0001_2345, 32'h0006_789A);
    tick();
    idle();
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.hi !== '0) begin errors++; $display("FAIL rstmid_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== '0) begin errors++; $display("FAIL rstmid_lo got %h want 0", bus.lo); end
    @(negedge clk) rst = 1'b0;
    m_hi = '0; m_lo = '0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_after_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_div_en0();
    bus_nd.id_valid = 1'b1; bus_nd.flush = 1'b0; bus_nd.id_op = 6'd0;
    bus_nd.id_funct = FN_MTHI; bus_nd.rs_val = 32'hAAAA_5555; bus_nd.rt_val = '0;
    tick();
    bus_nd.id_funct = FN_MTLO; bus_nd.rs_val = 32'h1234_5678;
    tick();
    bus_nd.id_funct = FN_DIVU; bus_nd.rs_val = 32'd100; bus_nd.rt_val = 32'd7; #1;
    checks++; if (bus_nd.stall !== 1'b0) begin errors++; $display("FAIL nodiv_stall got %b want 0", bus_nd.stall); end
    checks++; if (bus_nd.unsup !== 1'b0) begin errors++; $display("FAIL nodiv_unsup_early got %b want 0", bus_nd.unsup); end
    tick();
    bus_nd.id_valid = 1'b0; bus_nd.id_funct = 6'd0; #1;
    checks++; if (bus_nd.unsup !== 1'b1) begin errors++; $display("FAIL nodiv_unsup_pulse got %b want 1", bus_nd.unsup); end
    checks++; if (bus_nd.busy !== 1'b0) begin errors++; $display("FAIL nodiv_busy got %b want 0", bus_nd.busy); end
    tick();
    checks++; if (bus_nd.unsup !== 1'b0) begin errors++; $display("FAIL nodiv_unsup_end got %b want 0", bus_nd.unsup); end
    checks++; if (bus_nd.hi !== 32'hAAAA_5555) begin errors++; $display("FAIL nodiv_hi got %h want aaaa5555", bus_nd.hi); end
    checks++; if (bus_nd.lo !== 32'h1234_5678) begin errors++; $display("FAIL nodiv_lo got %h want 12345678", bus_nd.lo); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus_nd.id_valid = 1'b0; bus_nd.flush = 1'b0; bus_nd.id_op = '0;
    bus_nd.id_funct = '0; bus_nd.rs_val = '0; bus_nd.rt_val = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_stall_mfhi();
    test_mthi();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_div_en0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide control and execution unit for the 5-stage MIPS pipeline, sitting beside the ID-stage decoder.
- Decodes R-type mult/multu/div/divu/mfhi/mflo/mthi/mtlo from ID, runs an iterative radix-2 multiply or divide, and owns the HI/LO registers.
- Drives a stall request to the hazard logic while a result is pending.
- Parametrised in data width, with optional divide support.

Parameters:
XLEN, 32, operand/HI/LO width; must be ≥4 and even.
DIV_EN, 1, 1 = divide supported; 0 = div/divu are not executed and pulse unsup.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID-stage instruction valid
flush  in  1  squash ID instruction this cycle (IF_Flush)
id_op  in  6  instruction[31:26]
id_funct  in  6  instruction[5:0]
rs_val  in  XLEN  forwarded rs operand
rt_val  in  XLEN  forwarded rt operand
stall  out  1  hold IF/ID/PC and bubble EX
busy  out  1  iterative operation in flight
unsup  out  1  one-cycle pulse: div/divu seen with DIV_EN=0
hi  out  XLEN  HI register
lo  out  XLEN  LO register
mf_data  out  XLEN  hi for mfhi, lo for mflo, else 0 (combinational)

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, hi=lo=0, busy=0, unsup=0, iteration counter=0, partial registers=0. stall and mf_data are combinational.
- Decode: an instruction is "live" when id_valid & ~flush & id_op==0.
- Funct codes: mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13, mult 0x18, multu 0x19, div 0x1A, divu 0x1B.
- Stall rule: stall = live & busy & funct ∈ {mfhi, mflo, mthi, mtlo, mult, multu, div, divu}. Any other instruction proceeds while busy.
- Issue: in IDLE, a live mult/multu (or div/divu with DIV_EN=1) latches rs/rt at edge E0.
  - The operation is signed for mult/div; operands are converted to magnitude with sign flags kept.
  - State goes to MUL or DIV and busy=1.
- MUL/DIV: one shift-add or restoring-subtract step per cycle, XLEN cycles, counter XLEN-1 down to 0. Then the FIX state runs one cycle.
- FIX: applies sign correction and writes hi/lo, then returns to IDLE.
  - Multiply: {hi,lo} = 2·XLEN-bit product.
  - Divide: lo = quotient, hi = remainder. The remainder sign follows the dividend; the quotient is negative when the operand signs differ.
- Latency: hi/lo are updated and busy falls at edge E0+XLEN+1, so busy is high for XLEN+1 cycles (33 for XLEN=32). An mfhi stalled behind the operation reads the new value in the first unstalled cycle.
- mthi/mtlo: live in IDLE → hi or lo = rs_val at the next edge. No busy.
- mfhi/mflo: mf_data is valid in the same cycle when not stalled.
- Divide by zero: lo = all ones, hi = dividend (rs_val unmodified).
- Signed overflow (−2^(XLEN−1) / −1): lo = −2^(XLEN−1), hi = 0.
- DIV_EN=0: div/divu cause no state change and no stall; unsup = 1 for exactly that cycle (registered, so it appears in the following cycle).
- A flush in the same cycle as an issue prevents the issue. A flush does not abort an already-issued operation.
- A new mul/div while busy is stalled, then issues in the cycle after busy falls. There are no back-to-back gaps beyond that.

Decomposition:
- Package muldiv_pkg: funct code localparams (FN_MFHI … FN_DIVU), state enum {IDLE, MUL, DIV, FIX}, XLEN default.
- Sub-module mdu_iter_core: the shift/add/subtract datapath with start/step/done and the unsigned result.
- The top level holds decode, stall, sign handling, FSM, and HI/LO.

Test Plan:
- mult rs=7, rt=0xFFFFFFF9 (−7) → after 33 cycles lo=0xFFFFFFCF, hi=0xFFFFFFFF; busy high for exactly 33 cycles.
- divu rs=100, rt=7 → lo=14, hi=2. div rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div rs=5, rt=0 → lo=0xFFFFFFFF, hi=5. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- multu 0xFFFFFFFF × 0xFFFFFFFF immediately followed by mfhi → stall asserted 33 cycles, then mf_data=0xFFFFFFFE; and lo=1. An add issued mid-operation does not stall.
- mthi 0x1234 then mflo/mfhi with no stall → hi=0x1234, mf_data matches. Flush on a mult cycle → no busy.
- Assert rst at iteration 10 of a mult → busy=0, hi=lo=0 immediately. DIV_EN=0 build: divu → unsup pulse, hi/lo unchanged, no stall.
